// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice:
//   - arb_state_e : lock FSM encoding (IDLE, LOCK0, LOCK1)
//   - PORT0/PORT1 : requester indices into two-bit valid/grant vectors
//   - MEM_DEPTH / MEM_IDX_W : data memory depth and the address bits it decodes
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  localparam int unsigned PORT0     = 0;
  localparam int unsigned PORT1     = 1;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned MEM_IDX_W = 10;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// rr_pick2
// Pure combinational two-requester arbiter.
// Ports:
//   valid      in  [1:0] request vector, bit n = port n
//   last_grant in  1     port that won the most recent access
//   rr_en      in  1     1 = round-robin on contention, 0 = port 0 always wins
//   gnt        out [1:0] one-hot grant (all zero when nobody requests)
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (valid[PORT0] && valid[PORT1]) begin
      // On contention, round-robin hands the grant to whoever did not win last.
      if (rr_en && !last_grant) begin
        gnt[PORT1] = 1'b1;
      end else begin
        gnt[PORT0] = 1'b1;
      end
    end else begin
      gnt = valid;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares a single-port data memory (1-cycle registered read) between the CPU
// load/store stage (port 0) and the debug/loader port (port 1).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pN_valid/ready           request handshake for port N
//   pN_we, pN_lock           request type (1 = write) and grant-lock request
//   pN_addr, pN_wdata        word address and write data
//   pN_rvalid, pN_rdata      read return, one cycle after the read is accepted
//   mem_addr, mem_wrData     address / write data to the memory
//   mem_wrMem, mem_rdMem     memory write / read strobes
//   mem_rdData               registered read data from the memory
//
// Handshake: a request is accepted in the cycle where pN_valid and pN_ready are
// both high; ready is a combinational function of the current valids, lock
// state and last grant. Requesters keep valid/we/addr/wdata stable until they
// see ready. The memory operation is committed at the next rising edge.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrData,
  output logic              mem_wrMem,
  output logic              mem_rdMem,
  input  logic [DATA_W-1:0] mem_rdData
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_port;
  logic              sel_we;
  logic              sel_lock;

  // A held lock masks the other port out before arbitration.
  always_comb begin
    req = 2'b00;
    case (state_q)
      ST_IDLE:  req = {p1_valid, p0_valid};
      ST_LOCK0: req = {1'b0, p0_valid};
      ST_LOCK1: req = {p1_valid, 1'b0};
      default:  req = 2'b00;
    endcase
  end

  rr_pick2 u_pick (
    .valid      (req),
    .last_grant (last_grant_q),
    .rr_en      (RR_EN),
    .gnt        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    any_gnt      = gnt[PORT0] | gnt[PORT1];
    sel_port     = gnt[PORT1];
    sel_we       = 1'b0;
    sel_lock     = 1'b0;

    if (gnt[PORT1]) begin
      addr_d   = p1_addr;
      wdata_d  = p1_wdata;
      sel_we   = p1_we;
      sel_lock = p1_lock;
    end else if (gnt[PORT0]) begin
      addr_d   = p0_addr;
      wdata_d  = p0_wdata;
      sel_we   = p0_we;
      sel_lock = p0_lock;
    end

    if (any_gnt) begin
      last_grant_d = sel_port;
      if (!sel_we) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = sel_port;
      end
    end

    // The lock is released on any cycle its owner drops pN_lock, whether or
    // not that cycle carries an access.
    case (state_q)
      ST_IDLE: begin
        if (any_gnt && sel_lock) begin
          state_d = sel_port ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0: if (!p0_lock) state_d = ST_IDLE;
      ST_LOCK1: if (!p1_lock) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // addr_d/wdata_d already fall back to the held values when nobody is granted.
  assign mem_addr   = addr_d;
  assign mem_wrData = wdata_d;
  assign mem_wrMem  = any_gnt &  sel_we & ~rst;
  assign mem_rdMem  = any_gnt & ~sel_we & ~rst;

  assign p0_ready   = gnt[PORT0] & ~rst;
  assign p1_ready   = gnt[PORT1] & ~rst;

  assign p0_rvalid  = rd_pend_q & ~rd_owner_q;
  assign p1_rvalid  = rd_pend_q &  rd_owner_q;
  assign p0_rdata   = p0_rvalid ? mem_rdData : '0;
  assign p1_rdata   = p1_rvalid ? mem_rdData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          p0_valid, p0_we, p0_lock, p1_valid, p1_we, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;

  logic          p0_ready, p0_rvalid, p1_ready, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wrData, mem_rdData;
  logic          mem_wrMem, mem_rdMem;

  logic          fp_p0_ready, fp_p0_rvalid, fp_p1_ready, fp_p1_rvalid;
  logic [DW-1:0] fp_p0_rdata, fp_p1_rdata;
  logic [AW-1:0] fp_mem_addr;
  logic [DW-1:0] fp_mem_wrData, fp_mem_rdData;
  logic          fp_mem_wrMem, fp_mem_rdMem;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wrData(mem_wrData), .mem_wrMem(mem_wrMem),
    .mem_rdMem(mem_rdMem), .mem_rdData(mem_rdData)
  );

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(fp_p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
    .p1_valid(p1_valid), .p1_ready(fp_p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
    .mem_addr(fp_mem_addr), .mem_wrData(fp_mem_wrData), .mem_wrMem(fp_mem_wrMem),
    .mem_rdMem(fp_mem_rdMem), .mem_rdData(fp_mem_rdData)
  );

  // ---------------- memory models ----------------
  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      0: return 32'd57;  1: return 32'd23;  2: return 32'd89;  3: return 32'd45;
      4: return 32'd76;  5: return 32'd12;  6: return 32'd34;  7: return 32'd98;
      8: return 32'd67;  9: return 32'd29;
      default: return 32'(i * 13 + 5);
    endcase
  endfunction

  logic [DW-1:0] mem_a [MEM_DEPTH];
  logic [DW-1:0] mem_b [MEM_DEPTH];
  logic [DW-1:0] ref_mem [MEM_DEPTH];

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem_a[i] = init_val(i);
      mem_b[i] = init_val(i);
    end
    forever begin
      @(posedge clk);
      if (mem_wrMem)    mem_a[mem_addr[MEM_IDX_W-1:0]] = mem_wrData;
      if (mem_rdMem)    mem_rdData <= mem_a[mem_addr[MEM_IDX_W-1:0]];
      if (fp_mem_wrMem) mem_b[fp_mem_addr[MEM_IDX_W-1:0]] = fp_mem_wrData;
      if (fp_mem_rdMem) fp_mem_rdData <= mem_b[fp_mem_addr[MEM_IDX_W-1:0]];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_p0(input logic v, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_valid = v; p0_we = we; p0_lock = lk; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_valid = v; p1_we = we; p1_lock = lk; p1_addr = a; p1_wdata = d;
  endtask

  task automatic idle_all();
    set_p0(1'b0, 1'b0, 1'b0, '0, '0);
    set_p1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct packed {
    logic v0, v1;
    logic rr0, rr1;
    logic fp0, fp1;
  } vec_t;
  vec_t tbl [8];

  // ---------------- reference model state ----------------
  int            owner, last, g;
  bit            addr_known, hold0, hold1, acc0, acc1, e_valid;
  logic [AW-1:0] exp_addr, a_g;
  logic [DW-1:0] exp_wdata, d_g;
  logic          we_g, lk_g, rv0, rv1;
  logic [32:0]   exp_q [$];
  logic [32:0]   e;

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_val(i);

    tbl[0] = 6'b11_10_10;
    tbl[1] = 6'b11_01_10;
    tbl[2] = 6'b01_01_01;
    tbl[3] = 6'b11_10_10;
    tbl[4] = 6'b10_10_10;
    tbl[5] = 6'b11_01_10;
    tbl[6] = 6'b00_00_00;
    tbl[7] = 6'b11_10_10;

    // Reset state, with a request present to show strobes stay low.
    rst = 1'b1;
    idle_all();
    set_p0(1'b1, 1'b0, 1'b0, 32'd0, '0);
    #2;
    check("rst_rdMem", mem_rdMem, 0);
    check("rst_wrMem", mem_wrMem, 0);
    check("rst_p0_ready", p0_ready, 0);
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    idle_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single p0 read of addr 0.
    @(negedge clk);
    set_p0(1'b1, 1'b0, 1'b0, 32'd0, '0);
    #1;
    check("t1_p0_ready", p0_ready, 1);
    check("t1_rdMem", mem_rdMem, 1);
    check("t1_mem_addr", mem_addr, 0);
    @(negedge clk);
    idle_all();
    #1;
    check("t1_p0_rvalid", p0_rvalid, 1);
    check("t1_p0_rdata", p0_rdata, 57);
    check("t1_p1_rvalid", p1_rvalid, 0);

    // Round-robin contention: p0 first after reset, then p1.
    do_reset();
    @(negedge clk);
    set_p0(1'b1, 1'b0, 1'b0, 32'd1, '0);
    set_p1(1'b1, 1'b0, 1'b0, 32'd2, '0);
    #1;
    check("t2_p0_ready", p0_ready, 1);
    check("t2_p1_ready_a", p1_ready, 0);
    @(negedge clk);
    set_p0(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("t2_p1_ready_b", p1_ready, 1);
    check("t2_p0_rvalid", p0_rvalid, 1);
    check("t2_p0_rdata", p0_rdata, 23);
    @(negedge clk);
    idle_all();
    #1;
    check("t2_p1_rvalid", p1_rvalid, 1);
    check("t2_p1_rdata", p1_rdata, 89);
    check("t2_p0_rvalid_off", p0_rvalid, 0);

    // Fixed priority: p0 starves p1 until it drops valid.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_p0(1'b1, 1'b0, 1'b0, 32'd0, '0);
      set_p1(1'b1, 1'b0, 1'b0, 32'd1, '0);
      #1;
      check("t3_fp_p0_ready", fp_p0_ready, 1);
      check("t3_fp_p1_ready", fp_p1_ready, 0);
    end
    @(negedge clk);
    set_p0(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("t3_fp_p1_ready_drop", fp_p1_ready, 1);

    // Table of contention patterns for both arbitration modes.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_p0(tbl[i].v0, 1'b0, 1'b0, 32'd0, '0);
      set_p1(tbl[i].v1, 1'b0, 1'b0, 32'd1, '0);
      #1;
      check($sformatf("tbl%0d_rr_p0_ready", i), p0_ready, tbl[i].rr0);
      check($sformatf("tbl%0d_rr_p1_ready", i), p1_ready, tbl[i].rr1);
      check($sformatf("tbl%0d_fp_p0_ready", i), fp_p0_ready, tbl[i].fp0);
      check($sformatf("tbl%0d_fp_p1_ready", i), fp_p1_ready, tbl[i].fp1);
      check($sformatf("tbl%0d_rdMem", i), mem_rdMem, tbl[i].v0 | tbl[i].v1);
    end

    // Back-to-back stream of 10 p0 reads.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) set_p0(1'b1, 1'b0, 1'b0, 32'(i), '0);
      else        idle_all();
      #1;
      if (i < 10) check($sformatf("str%0d_p0_ready", i), p0_ready, 1);
      if (i > 0) begin
        check($sformatf("str%0d_p0_rvalid", i), p0_rvalid, 1);
        check($sformatf("str%0d_p0_rdata", i), p0_rdata, init_val(i - 1));
      end
    end

    // Reset while a read return is pending.
    do_reset();
    @(negedge clk);
    set_p0(1'b1, 1'b0, 1'b0, 32'd3, '0);
    #1;
    check("t5_p0_ready", p0_ready, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rvalid_drop", p0_rvalid, 0);
    check("t5_rdata_drop", p0_rdata, 0);
    check("t5_rdMem_off", mem_rdMem, 0);
    check("t5_wrMem_off", mem_wrMem, 0);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_p0(1'b1, 1'b0, 1'b0, 32'd9, '0);
    #1;
    check("t5_no_stale_rvalid", p0_rvalid, 0);
    check("t5_p0_ready_after", p0_ready, 1);
    @(negedge clk);
    idle_all();
    #1;
    check("t5_p0_rvalid", p0_rvalid, 1);
    check("t5_p0_rdata", p0_rdata, 29);

    // p1 locked read-modify-write of addr 5 while p0 waits.
    do_reset();
    @(negedge clk);
    set_p1(1'b1, 1'b0, 1'b1, 32'd5, '0);
    #1;
    check("t4_p1_ready_rd", p1_ready, 1);
    @(negedge clk);
    set_p1(1'b1, 1'b1, 1'b1, 32'd5, 32'd99);
    set_p0(1'b1, 1'b0, 1'b0, 32'd5, '0);
    #1;
    check("t4_p1_ready_wr", p1_ready, 1);
    check("t4_p0_blocked_a", p0_ready, 0);
    check("t4_wrMem", mem_wrMem, 1);
    check("t4_p1_rvalid", p1_rvalid, 1);
    check("t4_p1_rdata", p1_rdata, 12);
    check("t4_p0_rvalid", p0_rvalid, 0);
    @(negedge clk);
    set_p1(1'b0, 1'b0, 1'b1, '0, '0);
    #1;
    check("t4_p0_blocked_hold", p0_ready, 0);
    @(negedge clk);
    p1_lock = 1'b0;
    #1;
    check("t4_p0_blocked_rel", p0_ready, 0);
    @(negedge clk);
    #1;
    check("t4_p0_ready", p0_ready, 1);
    @(negedge clk);
    idle_all();
    #1;
    check("t4_p0_rvalid", p0_rvalid, 1);
    check("t4_p0_rdata", p0_rdata, 99);
    ref_mem[5] = 32'd99;

    // Randomized traffic against the behavioural model.
    do_reset();
    owner = -1; last = 1; addr_known = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hold0 = p0_valid && !acc0;
      hold1 = p1_valid && !acc1;
      if (!hold0) begin
        p0_valid = ($urandom_range(0, 2) != 0);
        p0_we    = ($urandom_range(0, 2) == 0);
        p0_lock  = ($urandom_range(0, 3) == 0);
        p0_addr  = rand_addr();
        p0_wdata = $urandom();
      end
      if (!hold1) begin
        p1_valid = ($urandom_range(0, 2) != 0);
        p1_we    = ($urandom_range(0, 2) == 0);
        p1_lock  = ($urandom_range(0, 3) == 0);
        p1_addr  = rand_addr();
        p1_wdata = $urandom();
      end
      #1;

      e_valid = 1'b0;
      e = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_valid = 1'b1;
      end
      rv0 = e_valid && !e[32];
      rv1 = e_valid &&  e[32];

      if (owner >= 0)                g = ((owner == 0) ? p0_valid : p1_valid) ? owner : -1;
      else if (p0_valid && p1_valid) g = (last == 0) ? 1 : 0;
      else if (p0_valid)             g = 0;
      else if (p1_valid)             g = 1;
      else                           g = -1;

      we_g = (g == 1) ? p1_we    : p0_we;
      lk_g = (g == 1) ? p1_lock  : p0_lock;
      a_g  = (g == 1) ? p1_addr  : p0_addr;
      d_g  = (g == 1) ? p1_wdata : p0_wdata;

      check("rnd_p0_ready", p0_ready, g == 0);
      check("rnd_p1_ready", p1_ready, g == 1);
      check("rnd_wrMem", mem_wrMem, (g >= 0) && we_g);
      check("rnd_rdMem", mem_rdMem, (g >= 0) && !we_g);
      check("rnd_p0_rvalid", p0_rvalid, rv0);
      check("rnd_p1_rvalid", p1_rvalid, rv1);
      check("rnd_p0_rdata", p0_rdata, rv0 ? e[31:0] : 32'd0);
      check("rnd_p1_rdata", p1_rdata, rv1 ? e[31:0] : 32'd0);
      if (g >= 0) begin
        exp_addr  = a_g;
        exp_wdata = d_g;
        addr_known = 1'b1;
      end
      if (addr_known) begin
        check("rnd_mem_addr", mem_addr, exp_addr);
        check("rnd_mem_wrData", mem_wrData, exp_wdata);
      end

      if (g >= 0) begin
        if (we_g) ref_mem[a_g[MEM_IDX_W-1:0]] = d_g;
        else      exp_q.push_back({(g == 1), ref_mem[a_g[MEM_IDX_W-1:0]]});
        last = g;
      end
      if (owner >= 0) begin
        if (!((owner == 0) ? p0_lock : p1_lock)) owner = -1;
      end else if (g >= 0 && lk_g) begin
        owner = g;
      end
      acc0 = (g == 0);
      acc1 = (g == 1);
    end

    @(negedge clk);
    idle_all();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
